output_write_scheduler: RTL

- Sequences the output-SRAM write port for the convolution engine.
- Accepts one result pixel per handshake from the convolution modules and buffers it in a small FIFO.
- Packs pixels into SRAM words and emits a header word (output dims) at the start of each matrix.
- Flushes a zero-padded partial word at each row end and pulses done after the last row. Started by the top-level controller once per matrix; sole owner of the output SRAM write port.

---
 rtl/output_write_scheduler_pkg.sv | 26 ++
 rtl/output_write_scheduler_fifo.sv | 43 ++++
 rtl/output_write_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/output_write_scheduler_pkg.sv
// Shared definitions for the output-SRAM write scheduler: state encoding,
// pixel-per-word derivation and the header word layout.
package output_write_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Number of result pixels packed into one SRAM word.
  function automatic int pack_of(input int word_w, input int res_w);
    return word_w / res_w;
  endfunction

  // Header word: rows in the upper dimension field, columns in the lower one,
  // zero-extended; the caller truncates to the SRAM word width.
  function automatic logic [31:0] hdr_word(input logic [15:0] nrows,
                                           input logic [15:0] ncols,
                                           input int          dim_w);
    return (32'(nrows) << dim_w) | 32'(ncols);
  endfunction

endpackage

// File: rtl/output_write_scheduler_fifo.sv
// Small result-pixel FIFO between the convolution modules and the packer.
// Read data is presented combinationally from the head entry.
module result_fifo #(
  parameter int RES_W  = 8,
  parameter int FIFO_D = 4
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             push,
  input  logic [RES_W-1:0] din,
  input  logic             pop,
  output logic [RES_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_D);

  logic [RES_W-1:0] mem [FIFO_D];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/output_write_scheduler.sv
// Output-SRAM write scheduler: header word, pixel packing into SRAM words,
// zero-padded row-end flush and a done pulse per matrix.
module output_write_scheduler
  import output_write_scheduler_pkg::*;
#(
  parameter int RES_W  = 8,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 8,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [DIM_W-1:0]  out_nrows,
  input  logic [DIM_W-1:0]  out_ncols,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res_data,
  output logic              res_ready,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [WORD_W-1:0] dut_sram_write_data,
  output logic              busy,
  output logic              done
);

  localparam int PACK = pack_of(WORD_W, RES_W);
  localparam int PW   = (PACK > 1) ? $clog2(PACK) : 1;

  state_t             state, state_nxt;
  logic [DIM_W-1:0]   nrows_q, ncols_q, row_q, col_q;
  logic [PW-1:0]      pack_cnt;
  logic [WORD_W-1:0]  pack_q, pack_nxt;
  logic [WORD_W-1:0]  word_p1;
  logic               vld_p1;
  logic               last_pix_q;
  logic [ADDR_W-1:0]  wad;

  logic               fifo_full, fifo_empty, push, pop;
  logic [RES_W-1:0]   fifo_dout;
  logic               last_col, last_row, word_full, hdr_en, flush_en;

  result_fifo #(.RES_W(RES_W), .FIFO_D(FIFO_D)) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (push),
    .din     (res_data),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign push      = res_valid && res_ready;
  assign pop       = (state == ST_RUN) && !fifo_empty && !last_pix_q;
  assign last_col  = (col_q == ncols_q - 1'b1);
  assign last_row  = (row_q == nrows_q - 1'b1);
  assign word_full = (pack_cnt == PW'(PACK - 1));
  assign hdr_en    = (state == ST_HDR);
  assign flush_en  = (state == ST_FLUSH);

  // Drop the popped pixel into its lane; lane 0 sits in the LSBs.
  always_comb begin
    pack_nxt = pack_q;
    pack_nxt[int'(pack_cnt)*RES_W +: RES_W] = fifo_dout;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_b) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; after the final pixel, RUN lingers one cycle so the
  // last full word is written before DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_HDR;
      ST_HDR:   state_nxt = (out_dims_zero()) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (last_pix_q)                          state_nxt = ST_DONE;
        else if (pop && last_col && !word_full)  state_nxt = ST_FLUSH;
      end
      ST_FLUSH: state_nxt = last_pix_q ? ST_DONE : ST_RUN;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  function automatic logic out_dims_zero();
    return (nrows_q == '0) || (ncols_q == '0);
  endfunction

  // Output decode: header, flush and registered full word never overlap.
  always_comb begin
    dut_sram_write_enable  = hdr_en || flush_en || vld_p1;
    dut_sram_write_address = dut_sram_write_enable ? wad : '0;
    if (hdr_en)        dut_sram_write_data = WORD_W'(hdr_word(16'(nrows_q), 16'(ncols_q), DIM_W));
    else if (flush_en) dut_sram_write_data = pack_q;
    else if (vld_p1)   dut_sram_write_data = word_p1;
    else               dut_sram_write_data = '0;
    res_ready = !fifo_full && (hdr_en || flush_en || (state == ST_RUN));
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
  end

  // Control and packing state; row/col advance at the pop of the last column.
  always_ff @(posedge clk) begin
    if (reset_b) begin
      nrows_q    <= '0;
      ncols_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      pack_cnt   <= '0;
      pack_q     <= '0;
      vld_p1     <= 1'b0;
      last_pix_q <= 1'b0;
      wad        <= '0;
    end else begin
      vld_p1 <= pop && word_full;
      if (dut_sram_write_enable) wad <= wad + 1'b1;
      if ((state == ST_IDLE) && start) begin
        nrows_q    <= out_nrows;
        ncols_q    <= out_ncols;
        row_q      <= '0;
        col_q      <= '0;
        pack_cnt   <= '0;
        pack_q     <= '0;
        last_pix_q <= 1'b0;
      end
      if (pop) begin
        if (word_full) begin
          pack_q   <= '0;
          pack_cnt <= '0;
        end else begin
          pack_q   <= pack_nxt;
          pack_cnt <= pack_cnt + 1'b1;
        end
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
          if (last_row) last_pix_q <= 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (flush_en) begin
        pack_q   <= '0;
        pack_cnt <= '0;
      end
    end
  end

  // p0 -> p1: completed word captured for the following write cycle.
  always_ff @(posedge clk) begin
    if (pop && word_full) word_p1 <= pack_nxt;
  end

endmodule
